// File: rtl/seg_pkg.sv
// Shared definitions for the segment display scheduler: FSM states,
// special receive bytes, the blank segment pattern and ASCII hex helpers.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  localparam logic [7:0] CR_BYTE     = 8'h0D;
  localparam logic [7:0] CLR_BYTE    = 8'h23;
  localparam logic [7:0] BLANK       = 8'hFF;
  localparam int         NUM_DIG_DEF = 6;

  // True for ASCII '0'-'9', 'a'-'f', 'A'-'F'.
  function automatic logic is_hex(input logic [7:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) ||
           ((b >= 8'h41) && (b <= 8'h46)) ||
           ((b >= 8'h61) && (b <= 8'h66));
  endfunction

  // Nibble value of an ASCII hex character (letters of either case).
  function automatic logic [3:0] hex_nib(input logic [7:0] b);
    if (b <= 8'h39) return b[3:0];
    return b[3:0] + 4'd9;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment decode (bit7 = dp, off).
module hex_to_seg (
  input  logic [3:0] nib,
  output logic [7:0] seg
);

  // Lookup of segments g..a for each hex value; dp kept high.
  always_comb begin
    seg = 8'hFF;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
  end

endmodule

// File: rtl/seg_disp_sched.sv
// Serial hex byte collector driving a multiplexed 6-digit seven-segment display.
// Optional build macro SEG_LEAD_BLANK_EN blanks leading zeros of the shown value.
module seg_disp_sched
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int NUM_DIG  = NUM_DIG_DEF
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               rx_sig,
  input  logic [7:0]         rdata,
  output logic [7:0]         led_data,
  output logic [NUM_DIG-1:0] led_sel,
  output logic               commit,
  output logic               ovf
);

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [2:0]      LAST_IDX = 3'(NUM_DIG - 1);
  localparam logic [2:0]      FULL_CNT = 3'(NUM_DIG);

  state_e     state_q, state_d;
  logic [3:0] pend_q [NUM_DIG];
  logic [3:0] pend_d [NUM_DIG];
  logic [3:0] disp_q [NUM_DIG];
  logic [3:0] disp_d [NUM_DIG];
  logic [2:0] pend_cnt_q, pend_cnt_d;
  logic [2:0] disp_cnt_q, disp_cnt_d;
  logic       ovf_q, ovf_d;
  logic       commit_q, commit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] led_data_q, led_data_d;
  logic [NUM_DIG-1:0] led_sel_q, led_sel_d;
  logic [7:0] seg_out;
  logic       lead_zero;

  // Byte classification, pending shift register and commit/clear handling.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_cnt_d = pend_cnt_q;
    disp_d     = disp_q;
    disp_cnt_d = disp_cnt_q;
    ovf_d      = ovf_q;
    commit_d   = 1'b0;
    if (state_q == ST_COMMIT) begin
      // Any byte seen here is ignored; pending moves to the display.
      disp_d     = pend_q;
      disp_cnt_d = pend_cnt_q;
      pend_d     = '{default: 4'h0};
      pend_cnt_d = 3'd0;
      commit_d   = 1'b1;
      state_d    = ST_IDLE;
    end else if (rx_sig) begin
      if (is_hex(rdata)) begin
        if (pend_cnt_q == FULL_CNT) begin
          ovf_d = 1'b1;
        end else begin
          for (int i = 1; i < NUM_DIG; i++) pend_d[i] = pend_q[i-1];
          pend_d[0]  = hex_nib(rdata);
          pend_cnt_d = pend_cnt_q + 3'd1;
          state_d    = ST_COLLECT;
        end
      end else if (rdata == CR_BYTE) begin
        state_d = ST_COMMIT;
      end else if (rdata == CLR_BYTE) begin
        pend_d     = '{default: 4'h0};
        pend_cnt_d = 3'd0;
        disp_d     = '{default: 4'h0};
        disp_cnt_d = 3'd0;
        ovf_d      = 1'b0;
        state_d    = ST_IDLE;
      end
    end
  end

  // Scan divider and digit index advance.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
    end
  end

`ifdef SEG_LEAD_BLANK_EN
  // Digit is a leading zero when it and every higher shown digit are zero.
  always_comb begin
    lead_zero = 1'b0;
    if (idx_d != 3'd0) begin
      lead_zero = 1'b1;
      for (int i = 0; i < NUM_DIG; i++) begin
        if ((3'(i) >= idx_d) && (3'(i) < disp_cnt_d) && (disp_d[i] != 4'h0))
          lead_zero = 1'b0;
      end
    end
  end
`else
  assign lead_zero = 1'b0;
`endif

  hex_to_seg u_hex_to_seg (
    .nib (disp_d[idx_d]),
    .seg (seg_out)
  );

  // Output pair built from next-state index and display so both always agree.
  always_comb begin
    led_sel_d  = ~(NUM_DIG'(1) << idx_d);
    led_data_d = ((idx_d >= disp_cnt_d) || lead_zero) ? BLANK : seg_out;
  end

  // State registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_q     <= '{default: 4'h0};
      disp_q     <= '{default: 4'h0};
      pend_cnt_q <= 3'd0;
      disp_cnt_q <= 3'd0;
      ovf_q      <= 1'b0;
      commit_q   <= 1'b0;
      div_q      <= '0;
      idx_q      <= 3'd0;
      led_data_q <= BLANK;
      led_sel_q  <= ~NUM_DIG'(1);
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      disp_q     <= disp_d;
      pend_cnt_q <= pend_cnt_d;
      disp_cnt_q <= disp_cnt_d;
      ovf_q      <= ovf_d;
      commit_q   <= commit_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      led_data_q <= led_data_d;
      led_sel_q  <= led_sel_d;
    end
  end

  assign led_data = led_data_q;
  assign led_sel  = led_sel_q;
  assign commit   = commit_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Self-checking bench for seg_disp_sched with a fast scan divider.
module tb_seg_disp_sched;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_sig = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic [7:0] led_data;
  logic [5:0] led_sel;
  logic       commit;
  logic       ovf;

  int errors = 0;
  int checks = 0;
  int k = 0;  // edges since last reset edge

  // Reference model state
  logic [3:0] m_pend[$];
  logic [3:0] m_disp[6];
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;
  logic [7:0] seg_tab[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_disp_sched #(.SCAN_DIV(4), .NUM_DIG(6)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .rx_sig   (rx_sig),
    .rdata    (rdata),
    .led_data (led_data),
    .led_sel  (led_sel),
    .commit   (commit),
    .ovf      (ovf)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_is_hex(input logic [7:0] b);
    return (b >= "0" && b <= "9") || (b >= "a" && b <= "f") || (b >= "A" && b <= "F");
  endfunction

  function automatic logic [3:0] m_nib(input logic [7:0] b);
    if (b >= "0" && b <= "9") return 4'(b - "0");
    if (b >= "a" && b <= "f") return 4'(b - "a" + 10);
    return 4'(b - "A" + 10);
  endfunction

  function automatic logic [7:0] exp_led(input int i);
    if (i >= m_cnt) return 8'hFF;
`ifdef SEG_LEAD_BLANK_EN
    if (i > 0) begin
      bit all_zero = 1'b1;
      for (int j = i; j < m_cnt; j++) if (m_disp[j] != 0) all_zero = 1'b0;
      if (all_zero) return 8'hFF;
    end
`endif
    return seg_tab[m_disp[i]];
  endfunction

  task automatic model_clear_all();
    m_pend.delete();
    for (int i = 0; i < 6; i++) m_disp[i] = 4'h0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // One-cycle strobe of a non-CR byte, with model update.
  task automatic send_byte(input logic [7:0] b);
    @(negedge sys_clk);
    rx_sig = 1'b1;
    rdata  = b;
    if (m_is_hex(b)) begin
      if (m_pend.size() < 6) m_pend.push_front(m_nib(b));
      else m_ovf = 1'b1;
    end else if (b == 8'h23) begin
      model_clear_all();
    end
    @(negedge sys_clk);
    rx_sig = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // CR, optionally followed by a byte landing during the commit cycle.
  task automatic send_cr(input bit follow_en, input logic [7:0] follow);
    @(negedge sys_clk);
    rx_sig = 1'b1;
    rdata  = 8'h0D;
    @(negedge sys_clk);
    rx_sig = follow_en;
    rdata  = follow;
    chk("commit_before", {31'd0, commit}, 32'd0);
    @(negedge sys_clk);
    rx_sig = 1'b0;
    for (int i = 0; i < 6; i++) m_disp[i] = (i < m_pend.size()) ? m_pend[i] : 4'h0;
    m_cnt = m_pend.size();
    m_pend.delete();
    chk("commit_pulse", {31'd0, commit}, 32'd1);
    @(negedge sys_clk);
    chk("commit_after", {31'd0, commit}, 32'd0);
    chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
  endtask

  // Compare outputs over n cycles against the scan/display model.
  task automatic check_scan(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      int idx;
      idx = (k / 4) % 6;
      chk({tag, "_sel"}, {26'd0, led_sel}, {26'd0, ~(6'b1 << idx)});
      chk({tag, "_data"}, {24'd0, led_data}, {24'd0, exp_led(idx)});
      @(negedge sys_clk);
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;
    model_clear_all();
  endtask

  initial begin
    logic [7:0] b;
    int len;
    logic [3:0] nib;

    // Reset state
    do_reset();
    chk("rst_data", {24'd0, led_data}, 32'hFF);
    chk("rst_sel", {26'd0, led_sel}, 32'h3E);
    chk("rst_commit", {31'd0, commit}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    check_scan(48, "scan_blank");

    // "12AB" CR
    send_str("12AB");
    send_cr(1'b0, 8'h00);
    check_scan(24, "12AB");

    // Seven digits overflow; last one lost
    send_str("1234567");
    send_cr(1'b0, 8'h00);
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    check_scan(24, "ovf6");

    // Clear then CR: blank and ovf cleared
    send_str("5");
    send_byte("#");
    send_cr(1'b0, 8'h00);
    chk("ovf_clr", {31'd0, ovf}, 32'd0);
    check_scan(24, "clr");

    // Reset during collection discards pending
    send_str("99");
    do_reset();
    send_cr(1'b0, 8'h00);
    check_scan(24, "rst_mid");

    // Leading zero case (blanking depends on build macro)
    send_str("0070");
    send_cr(1'b0, 8'h00);
    check_scan(24, "lead0");

    // Byte during COMMIT is ignored
    send_str("3");
    send_cr(1'b1, "4");
    check_scan(24, "in_commit");
    send_cr(1'b0, 8'h00);
    check_scan(24, "in_commit_empty");

    // Randomized sequences with junk bytes interleaved
    for (int it = 0; it < 30; it++) begin
      len = $urandom_range(0, 8);
      for (int d = 0; d < len; d++) begin
        if ($urandom_range(0, 3) == 0) begin
          do b = 8'($urandom_range(0, 255));
          while (m_is_hex(b) || b == 8'h0D || b == 8'h23);
          send_byte(b);
        end
        if ($urandom_range(0, 15) == 0) send_byte("#");
        nib = 4'($urandom_range(0, 15));
        if (nib < 10) b = 8'("0" + nib);
        else b = 8'((($urandom_range(0, 1) != 0) ? "a" : "A") + nib - 10);
        send_byte(b);
      end
      send_cr(1'b0, 8'h00);
      check_scan(24, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
